// File: rtl/decoder_mc.sv
// Multi-cycle RV32I main decoder: combinational field decode plus a three-state
// sequencer that stalls the PC across data-memory accesses and holds trap causes.
module decoder_mc #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        trap_ack,
  output logic [1:0]  srcA,
  output logic [2:0]  srcB,
  output logic [4:0]  aop,
  output logic [2:0]  memi,
  output logic        mreq,
  output logic        mwe,
  output logic        rfwe,
  output logic        ws,
  output logic        b,
  output logic        jal,
  output logic        jalr,
  output logic        enpc,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [1:0] S_DECODE   = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_TRAP     = 2'd2;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [1:0]      state_reg;
  logic [31:0]     ilat_reg;
  logic [TO_W-1:0] cnt_reg;
  logic            ill_reg;
  logic            berr_reg;

  // In MEM_WAIT the held instruction drives the decoder, not the fetch bus.
  logic [31:0] dw;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        unused_bits;

  assign dw          = (state_reg == S_MEM_WAIT) ? ilat_reg : instr;
  assign opc         = dw[6:0];
  assign f3          = dw[14:12];
  assign f7          = dw[31:25];
  assign unused_bits = ^{dw[24:15], dw[11:7]};

  logic       d_legal;
  logic [1:0] d_srca;
  logic [2:0] d_srcb;
  logic [4:0] d_aop;
  logic [2:0] d_memi;
  logic       d_mreq, d_mwe, d_rfwe, d_ws, d_b, d_jal, d_jalr;

  always_comb begin
    d_legal = 1'b0;
    d_srca  = 2'd0;
    d_srcb  = 3'd0;
    d_aop   = 5'd0;
    d_memi  = 3'd0;
    d_mreq  = 1'b0;
    d_mwe   = 1'b0;
    d_rfwe  = 1'b0;
    d_ws    = 1'b0;
    d_b     = 1'b0;
    d_jal   = 1'b0;
    d_jalr  = 1'b0;
    if (dw[1:0] == 2'b11) begin
      case (opc)
        OP_R: begin
          d_legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
          d_aop   = {2'b00, f7[5], f3};
          d_rfwe  = 1'b1;
        end
        OP_IMM: begin
          d_legal = !((f3 == 3'd1) && (f7 != 7'h00)) &&
                    !((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
          d_srcb  = 3'd1;
          d_aop   = {2'b00, (f3 == 3'd5) & f7[5], f3};
          d_rfwe  = 1'b1;
        end
        OP_LOAD: begin
          d_legal = !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
          d_srcb  = 3'd1;
          d_memi  = f3;
          d_mreq  = 1'b1;
          d_ws    = 1'b1;
        end
        OP_STORE: begin
          d_legal = (f3 <= 3'd2);
          d_srcb  = 3'd3;
          d_memi  = f3;
          d_mreq  = 1'b1;
          d_mwe   = 1'b1;
        end
        OP_BRANCH: begin
          d_legal = !((f3 == 3'd2) || (f3 == 3'd3));
          d_aop   = {2'b11, f3};
          d_b     = 1'b1;
        end
        OP_JAL: begin
          d_legal = 1'b1;
          d_srca  = 2'd1;
          d_srcb  = 3'd4;
          d_jal   = 1'b1;
          d_rfwe  = 1'b1;
        end
        OP_JALR: begin
          d_legal = (f3 == 3'd0);
          d_srca  = 2'd1;
          d_srcb  = 3'd4;
          d_jalr  = 1'b1;
          d_rfwe  = 1'b1;
        end
        OP_LUI: begin
          d_legal = 1'b1;
          d_srca  = 2'd2;
          d_srcb  = 3'd2;
          d_rfwe  = 1'b1;
        end
        OP_AUIPC: begin
          d_legal = 1'b1;
          d_srca  = 2'd1;
          d_srcb  = 3'd2;
          d_rfwe  = 1'b1;
        end
        default: d_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    srcA    = 2'd0;
    srcB    = 3'd0;
    aop     = 5'd0;
    memi    = 3'd0;
    mreq    = 1'b0;
    mwe     = 1'b0;
    rfwe    = 1'b0;
    ws      = 1'b0;
    b       = 1'b0;
    jal     = 1'b0;
    jalr    = 1'b0;
    enpc    = 1'b0;
    illegal = ill_reg;
    bus_err = berr_reg;
    case (state_reg)
      S_DECODE: begin
        if (instr_valid) begin
          if (!d_legal) begin
            illegal = 1'b1;
          end else begin
            srcA = d_srca;
            srcB = d_srcb;
            aop  = d_aop;
            memi = d_memi;
            mreq = d_mreq;
            mwe  = d_mwe;
            ws   = d_ws;
            // Memory ops only issue here; write-back and PC advance wait for mem_ready.
            if (!d_mreq) begin
              rfwe = d_rfwe;
              b    = d_b;
              jal  = d_jal;
              jalr = d_jalr;
              enpc = 1'b1;
            end
          end
        end
      end
      S_MEM_WAIT: begin
        srcA = d_srca;
        srcB = d_srcb;
        aop  = d_aop;
        memi = d_memi;
        mreq = d_mreq;
        mwe  = d_mwe;
        ws   = d_ws;
        enpc = mem_ready;
        rfwe = mem_ready & d_ws;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_DECODE;
      ilat_reg  <= 32'd0;
      cnt_reg   <= '0;
      ill_reg   <= 1'b0;
      berr_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_DECODE: begin
          if (instr_valid) begin
            if (!d_legal) begin
              ill_reg   <= 1'b1;
              state_reg <= S_TRAP;
            end else if (d_mreq) begin
              ilat_reg  <= instr;
              cnt_reg   <= '0;
              state_reg <= S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          // Completion takes priority over an expiring timeout.
          if (mem_ready) begin
            state_reg <= S_DECODE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if ((MEM_TIMEOUT != 0) && (cnt_reg == TO_LAST)) begin
              berr_reg  <= 1'b1;
              state_reg <= S_TRAP;
            end
          end
        end
        S_TRAP: begin
          if (trap_ack) begin
            ill_reg   <= 1'b0;
            berr_reg  <= 1'b0;
            state_reg <= S_DECODE;
          end
        end
        default: state_reg <= S_DECODE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_mc.sv
// Bench for decoder_mc: instruction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_decoder_mc;

  localparam int TO = 16;

  typedef struct packed {
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [4:0] aop;
    logic [2:0] memi;
    logic mreq, mwe, rfwe, ws, b, jal, jalr, enpc, illegal, bus_err;
  } outs_t;

  logic        clk, rst;
  logic [31:0] instr;
  logic        instr_valid, mem_ready, trap_ack;
  logic [1:0]  srcA;
  logic [2:0]  srcB;
  logic [4:0]  aop;
  logic [2:0]  memi;
  logic        mreq, mwe, rfwe, ws, b, jal, jalr, enpc, illegal, bus_err;

  decoder_mc #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .trap_ack(trap_ack),
    .srcA(srcA), .srcB(srcB), .aop(aop), .memi(memi), .mreq(mreq), .mwe(mwe),
    .rfwe(rfwe), .ws(ws), .b(b), .jal(jal), .jalr(jalr), .enpc(enpc),
    .illegal(illegal), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outs_t dut_o;
  assign dut_o = {srcA, srcB, aop, memi, mreq, mwe, rfwe, ws, b, jal, jalr, enpc, illegal, bus_err};

  int    errors = 0;
  int    checks = 0;
  bit    model_on;
  bit    pin_valid;
  outs_t pin_exp;
  string pin_name;

  // Model state: 0 = ready for instructions, 1 = memory access outstanding, 2 = trap.
  int          m_mode;
  logic [31:0] m_word;
  int          m_waited;
  bit          m_ill, m_berr;

  function automatic bit legal(logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic [7:0] ldm = 8'h37;
    logic [7:0] brm = 8'hF3;
    logic [7:0] shm = 8'h21;
    if (w[1:0] != 2'b11) return 1'b0;
    case (op)
      7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && shm[f3]);
      7'h13: begin
        if (f3 == 3'd1) return f7 == 7'h00;
        if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
        return 1'b1;
      end
      7'h03: return ldm[f3];
      7'h23: return f3 <= 3'd2;
      7'h63: return brm[f3];
      7'h67: return f3 == 3'd0;
      7'h6F, 7'h37, 7'h17: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_mem(logic [31:0] w);
    return (w[6:0] == 7'h03) || (w[6:0] == 7'h23);
  endfunction

  // Control word a legal instruction calls for, before any stall/enable gating.
  function automatic outs_t meaning(logic [31:0] w);
    outs_t o = '0;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    if (op == 7'h33) begin o.aop = {2'b00, f7[5], f3}; o.rfwe = 1'b1; end
    else if (op == 7'h13) begin
      o.srcb = 3'd1; o.aop = {2'b00, (f3 == 3'd5) ? f7[5] : 1'b0, f3}; o.rfwe = 1'b1;
    end
    else if (op == 7'h03) begin o.srcb = 3'd1; o.memi = f3; o.mreq = 1'b1; o.ws = 1'b1; end
    else if (op == 7'h23) begin o.srcb = 3'd3; o.memi = f3; o.mreq = 1'b1; o.mwe = 1'b1; end
    else if (op == 7'h63) begin o.aop = {2'b11, f3}; o.b = 1'b1; end
    else if (op == 7'h6F) begin o.srca = 2'd1; o.srcb = 3'd4; o.jal = 1'b1; o.rfwe = 1'b1; end
    else if (op == 7'h67) begin o.srca = 2'd1; o.srcb = 3'd4; o.jalr = 1'b1; o.rfwe = 1'b1; end
    else if (op == 7'h37) begin o.srca = 2'd2; o.srcb = 3'd2; o.rfwe = 1'b1; end
    else if (op == 7'h17) begin o.srca = 2'd1; o.srcb = 3'd2; o.rfwe = 1'b1; end
    return o;
  endfunction

  function automatic outs_t expected();
    outs_t o = '0;
    if (m_mode == 0) begin
      if (instr_valid) begin
        if (!legal(instr)) o.illegal = 1'b1;
        else begin
          o = meaning(instr);
          if (is_mem(instr)) o.rfwe = 1'b0;
          o.enpc = !is_mem(instr);
        end
      end
    end else if (m_mode == 1) begin
      o = meaning(m_word);
      o.enpc = mem_ready;
      o.rfwe = mem_ready && (m_word[6:0] == 7'h03);
    end else begin
      o.illegal = m_ill;
      o.bus_err = m_berr;
    end
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_word <= '0; m_waited <= 0; m_ill <= 1'b0; m_berr <= 1'b0;
    end else if (m_mode == 0) begin
      if (instr_valid) begin
        if (!legal(instr)) begin m_ill <= 1'b1; m_mode <= 2; end
        else if (is_mem(instr)) begin m_word <= instr; m_waited <= 0; m_mode <= 1; end
      end
    end else if (m_mode == 1) begin
      if (mem_ready) m_mode <= 0;
      else if (TO != 0 && m_waited + 1 == TO) begin m_berr <= 1'b1; m_mode <= 2; end
      else m_waited <= m_waited + 1;
    end else if (trap_ack) begin
      m_ill <= 1'b0; m_berr <= 1'b0; m_mode <= 0;
    end
  end

  always @(negedge clk) begin
    automatic outs_t want = expected();
    automatic int    c = 0;
    automatic int    e = 0;
    if (model_on && !rst) begin
      c++;
      if (dut_o !== want) begin
        e++;
        $display("FAIL model t=%0t instr=%h got=%h want=%h", $time, instr, dut_o, want);
      end
    end
    if (pin_valid) begin
      c++;
      if (dut_o !== pin_exp) begin
        e++;
        $display("FAIL %s t=%0t got=%h want=%h", pin_name, $time, dut_o, pin_exp);
      end
    end
    checks <= checks + c;
    errors <= errors + e;
  end

  task automatic step(input logic iv, input logic [31:0] in, input logic mr, input logic ack);
    @(posedge clk);
    #1;
    instr_valid = iv; instr = in; mem_ready = mr; trap_ack = ack; pin_valid = 1'b0;
  endtask

  task automatic pin(input outs_t want, input string nm);
    pin_exp = want; pin_name = nm; pin_valid = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 11);
    int r = $urandom_range(0, 3);
    case (k)
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2, 9: w[6:0] = 7'h03;
      3, 10: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h6F;
      6: w[6:0] = 7'h67;
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      default: ;
    endcase
    if (r == 0) w[31:25] = 7'h00;
    else if (r == 1) w[31:25] = 7'h20;
    if (w[6:0] == 7'h67 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
    return w;
  endfunction

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'h0000A283;
  localparam logic [31:0] SW  = 32'h0050A223;

  initial begin
    outs_t z, e;
    int pct;
    z = '0;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; mem_ready = 1'b0; trap_ack = 1'b0;
    pin_valid = 1'b0; model_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; model_on = 1'b1;
    pin(z, "reset_idle");

    step(1'b1, ADD, 1'b0, 1'b0);
    e = z; e.rfwe = 1'b1; e.enpc = 1'b1; pin(e, "add");

    step(1'b1, LW, 1'b0, 1'b0);
    e = z; e.srcb = 3'd1; e.memi = 3'd2; e.mreq = 1'b1; e.ws = 1'b1; pin(e, "lw_issue");
    repeat (3) begin step(1'b0, '0, 1'b0, 1'b0); pin(e, "lw_wait"); end
    step(1'b0, '0, 1'b1, 1'b0);
    e.rfwe = 1'b1; e.enpc = 1'b1; pin(e, "lw_done");
    step(1'b0, '0, 1'b0, 1'b0); pin(z, "lw_after");

    step(1'b1, SW, 1'b0, 1'b0);
    e = z; e.srcb = 3'd3; e.memi = 3'd2; e.mreq = 1'b1; e.mwe = 1'b1; pin(e, "sw_issue");
    repeat (TO) begin step(1'b0, '0, 1'b0, 1'b0); pin(e, "sw_wait"); end
    e = z; e.bus_err = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0); pin(e, "sw_berr");
    step(1'b1, ADD, 1'b0, 1'b0); pin(e, "berr_hold");
    step(1'b0, '0, 1'b0, 1'b1); pin(e, "berr_ack_cycle");
    step(1'b0, '0, 1'b0, 1'b0); pin(z, "berr_clear");

    e = z; e.illegal = 1'b1;
    step(1'b1, 32'h0, 1'b0, 1'b0); pin(e, "ill_zero");
    step(1'b0, '0, 1'b0, 1'b1); pin(e, "ill_zero_ack");
    step(1'b0, '0, 1'b0, 1'b0); pin(z, "ill_zero_clear");
    step(1'b1, 32'h4000F033, 1'b0, 1'b0); pin(e, "ill_r");
    repeat (5) begin step(1'b1, ADD, 1'b1, 1'b0); pin(e, "ill_hold"); end
    step(1'b0, '0, 1'b0, 1'b1); pin(e, "ill_ack");
    step(1'b0, '0, 1'b0, 1'b0); pin(z, "ill_clear");

    step(1'b1, LW, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    pin(z, "rst_async");
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    pin(z, "rst_resume");
    step(1'b1, ADD, 1'b0, 1'b0);
    e = z; e.rfwe = 1'b1; e.enpc = 1'b1; pin(e, "add_after_rst");

    step(1'b1, LW, 1'b0, 1'b0);
    repeat (TO - 1) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    e = z; e.srcb = 3'd1; e.memi = 3'd2; e.mreq = 1'b1; e.ws = 1'b1; e.rfwe = 1'b1; e.enpc = 1'b1;
    pin(e, "ready_at_timeout");
    step(1'b0, '0, 1'b0, 1'b0); pin(z, "ready_at_timeout_after");

    for (int blk = 0; blk < 15; blk++) begin
      case ($urandom_range(0, 3))
        0: pct = 3;
        1: pct = 25;
        2: pct = 60;
        default: pct = 100;
      endcase
      for (int c = 0; c < 200; c++)
        step(($urandom % 100) < 80, rand_instr(), ($urandom % 100) < pct, ($urandom % 100) < 40);
    end

    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
